// File: rtl/framebuffer_arbiter_if.sv
// Bus bundle between the framebuffer arbiter and its environment:
// scan read side, host write side, swap control and the pixel RAM port.
interface framebuffer_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 36
);
    logic                  scan_req;
    logic [ADDR_WIDTH-1:0] scan_addr;
    logic [DATA_WIDTH-1:0] scan_rdata;
    logic                  scan_rvalid;
    logic                  frame_sync;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  swap_req;
    logic                  swap_pending;
    logic                  swap_done;
    logic                  display_bank;
    logic [ADDR_WIDTH:0]   ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Environment side: scan engine, host loader and the RAM itself
    modport master (
        output scan_req, scan_addr, frame_sync, wr_valid, wr_addr, wr_data,
               swap_req, ram_rdata,
        input  scan_rdata, scan_rvalid, wr_ready, swap_pending, swap_done,
               display_bank, ram_addr, ram_wdata, ram_we
    );

    // Arbiter side
    modport slave (
        input  scan_req, scan_addr, frame_sync, wr_valid, wr_addr, wr_data,
               swap_req, ram_rdata,
        output scan_rdata, scan_rvalid, wr_ready, swap_pending, swap_done,
               display_bank, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Double-buffered framebuffer arbiter: scan reads the front bank with
// absolute priority, host writes go through a 2-entry FIFO into the back
// bank, and bank swaps only happen at a frame boundary with the FIFO empty.
module framebuffer_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 36
) (
    input  logic                 clk_in,
    input  logic                 reset,
    framebuffer_arbiter_if.slave bus
);
    logic [ADDR_WIDTH-1:0] fifo_addr [2];
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            count;

    logic display_bank_q;
    logic swap_pending_q;
    logic swap_done_q;
    logic scan_rvalid_q;

    logic wr_ready_c;
    logic push;
    logic pop;
    logic swap_exec;

    // Handshake, drain and swap decisions; wr_ready depends on state only
    always_comb begin
        wr_ready_c = (count < 2'd2) && !swap_pending_q;
        push       = bus.wr_valid && wr_ready_c;
        pop        = !bus.scan_req && (count != 2'd0);
        swap_exec  = bus.frame_sync && swap_pending_q && (count == 2'd0);
    end

    // FIFO payload storage; only the pointers need a reset value
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_addr[tail] <= bus.wr_addr;
            fifo_data[tail] <= bus.wr_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Bank select, swap bookkeeping and read-valid pipeline
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            display_bank_q <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            scan_rvalid_q  <= 1'b0;
        end else begin
            scan_rvalid_q <= bus.scan_req;
            swap_done_q   <= swap_exec;
            if (swap_exec) begin
                display_bank_q <= ~display_bank_q;
                swap_pending_q <= 1'b0;
            end else if (bus.swap_req) begin
                swap_pending_q <= 1'b1;
            end
        end
    end

    // RAM port mux: scan read first, then FIFO head drain, else idle
    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_we    = 1'b0;
        if (bus.scan_req) begin
            bus.ram_addr = {display_bank_q, bus.scan_addr};
        end else if (count != 2'd0) begin
            bus.ram_addr  = {~display_bank_q, fifo_addr[head]};
            bus.ram_wdata = fifo_data[head];
            bus.ram_we    = 1'b1;
        end
    end

    assign bus.wr_ready     = wr_ready_c;
    assign bus.scan_rdata   = bus.ram_rdata;
    assign bus.scan_rvalid  = scan_rvalid_q;
    assign bus.swap_pending = swap_pending_q;
    assign bus.swap_done    = swap_done_q;
    assign bus.display_bank = display_bank_q;
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter: a per-cycle vector table plus
// hand-written sequences for the long scan burst and mid-operation reset.
module tb_framebuffer_arbiter;
    localparam int AW = 10;
    localparam int DW = 36;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    framebuffer_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    framebuffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          s_req;
        logic [AW-1:0] s_addr;
        logic          fs;
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          sw;
        logic          e_rdy;
        logic          e_we;
        logic [AW:0]   e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_rv;
        logic          e_pend;
        logic          e_done;
        logic          e_bank;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s_req, input logic [AW-1:0] s_addr, input logic fs,
                       input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic sw, input logic e_rdy, input logic e_we,
                       input logic [AW:0] e_addr, input logic [DW-1:0] e_wdata,
                       input logic e_rv, input logic e_pend, input logic e_done,
                       input logic e_bank);
        vec_t v;
        v.s_req = s_req; v.s_addr = s_addr; v.fs = fs; v.wv = wv; v.wa = wa;
        v.wd = wd; v.sw = sw; v.e_rdy = e_rdy; v.e_we = e_we; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_rv = e_rv; v.e_pend = e_pend; v.e_done = e_done;
        v.e_bank = e_bank;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.scan_req   = 1'b0;
        bus.scan_addr  = '0;
        bus.frame_sync = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.swap_req   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] wa[3];
        logic [DW-1:0] wd[3];
        int acc;
        int cnt_m;
        int got;
        logic push_m;
        logic pop_m;

        idle_inputs();
        bus.ram_rdata = 36'h0F0F0F0F0;

        // Reset state while reset is held low
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_bank", bus.display_bank, 0);
        chk("rst_pend", bus.swap_pending, 0);
        chk("rst_done", bus.swap_done, 0);
        chk("rst_rvalid", bus.scan_rvalid, 0);
        chk("rst_we", bus.ram_we, 0);
        chk("rst_ready", bus.wr_ready, 1);
        chk("rdata_pass", bus.scan_rdata, 36'h0F0F0F0F0);
        reset = 1'b1;

        // s_req s_addr fs wv wa wd sw | rdy we addr wdata rv pend done bank
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 1, 0, 11'h000, 36'h0,          0, 0, 0, 0);
        add(0, 10'h000, 0, 1, 10'h005, 36'hA5A5A5A5A,  0, 1, 0, 11'h000, 36'h0,          0, 0, 0, 0);
        add(0, 10'h000, 0, 1, 10'h006, 36'h123456789,  0, 1, 1, 11'h405, 36'hA5A5A5A5A,  0, 0, 0, 0);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 1, 1, 11'h406, 36'h123456789,  0, 0, 0, 0);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 1, 0, 11'h000, 36'h0,          0, 0, 0, 0);
        add(1, 10'h3C0, 0, 0, 10'h000, 36'h0,          0, 1, 0, 11'h3C0, 36'h0,          0, 0, 0, 0);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 1, 0, 11'h000, 36'h0,          1, 0, 0, 0);
        add(1, 10'h3C1, 0, 1, 10'h007, 36'h1,          0, 1, 0, 11'h3C1, 36'h0,          0, 0, 0, 0);
        add(1, 10'h3C2, 0, 1, 10'h008, 36'h2,          0, 1, 0, 11'h3C2, 36'h0,          1, 0, 0, 0);
        add(1, 10'h3C3, 0, 1, 10'h009, 36'h3,          0, 0, 0, 11'h3C3, 36'h0,          1, 0, 0, 0);
        add(0, 10'h000, 0, 1, 10'h009, 36'h3,          0, 0, 1, 11'h407, 36'h1,          1, 0, 0, 0);
        add(0, 10'h000, 0, 1, 10'h009, 36'h3,          0, 1, 1, 11'h408, 36'h2,          0, 0, 0, 0);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 1, 1, 11'h409, 36'h3,          0, 0, 0, 0);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 1, 0, 11'h000, 36'h0,          0, 0, 0, 0);
        add(0, 10'h000, 0, 1, 10'h00A, 36'h4,          0, 1, 0, 11'h000, 36'h0,          0, 0, 0, 0);
        add(1, 10'h010, 0, 0, 10'h000, 36'h0,          1, 1, 0, 11'h010, 36'h0,          0, 0, 0, 0);
        add(1, 10'h011, 1, 0, 10'h000, 36'h0,          0, 0, 0, 11'h011, 36'h0,          1, 1, 0, 0);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 0, 1, 11'h40A, 36'h4,          1, 1, 0, 0);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 0, 0, 11'h000, 36'h0,          0, 1, 0, 0);
        add(0, 10'h000, 1, 0, 10'h000, 36'h0,          0, 0, 0, 11'h000, 36'h0,          0, 1, 0, 0);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 1, 0, 11'h000, 36'h0,          0, 0, 1, 1);
        add(0, 10'h000, 0, 1, 10'h010, 36'h5,          0, 1, 0, 11'h000, 36'h0,          0, 0, 0, 1);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 1, 1, 11'h010, 36'h5,          0, 0, 0, 1);
        add(1, 10'h010, 0, 0, 10'h000, 36'h0,          0, 1, 0, 11'h410, 36'h0,          0, 0, 0, 1);
        add(0, 10'h000, 1, 0, 10'h000, 36'h0,          1, 1, 0, 11'h000, 36'h0,          1, 0, 0, 1);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          1, 0, 0, 11'h000, 36'h0,          0, 1, 0, 1);
        add(1, 10'h020, 1, 0, 10'h000, 36'h0,          0, 0, 0, 11'h420, 36'h0,          0, 1, 0, 1);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 1, 0, 11'h000, 36'h0,          1, 0, 1, 0);
        add(0, 10'h000, 1, 0, 10'h000, 36'h0,          0, 1, 0, 11'h000, 36'h0,          0, 0, 0, 0);
        add(0, 10'h000, 0, 0, 10'h000, 36'h0,          0, 1, 0, 11'h000, 36'h0,          0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.scan_req   = vecs[i].s_req;
            bus.scan_addr  = vecs[i].s_addr;
            bus.frame_sync = vecs[i].fs;
            bus.wr_valid   = vecs[i].wv;
            bus.wr_addr    = vecs[i].wa;
            bus.wr_data    = vecs[i].wd;
            bus.swap_req   = vecs[i].sw;
            #1;
            chk($sformatf("v%0d_ready", i), bus.wr_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d_we", i), bus.ram_we, vecs[i].e_we);
            chk($sformatf("v%0d_addr", i), bus.ram_addr, vecs[i].e_addr);
            if (vecs[i].e_we)
                chk($sformatf("v%0d_wdata", i), bus.ram_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_rvalid", i), bus.scan_rvalid, vecs[i].e_rv);
            chk($sformatf("v%0d_pend", i), bus.swap_pending, vecs[i].e_pend);
            chk($sformatf("v%0d_done", i), bus.swap_done, vecs[i].e_done);
            chk($sformatf("v%0d_bank", i), bus.display_bank, vecs[i].e_bank);
            @(posedge clk);
        end

        // 64-cycle scan burst over 0x3C0..0x3FF while the host offers 3 writes
        wa[0] = 10'h0B0; wa[1] = 10'h0B1; wa[2] = 10'h0B2;
        wd[0] = 36'hABCDE0001; wd[1] = 36'hABCDE0002; wd[2] = 36'hABCDE0003;
        acc = 0;
        cnt_m = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            idle_inputs();
            bus.scan_req  = 1'b1;
            bus.scan_addr = 10'h3C0 + AW'(i);
            if (acc < 3) begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = wa[acc];
                bus.wr_data  = wd[acc];
            end
            #1;
            chk("burst_addr", bus.ram_addr, {1'b0, 10'h3C0 + AW'(i)});
            chk("burst_we", bus.ram_we, 0);
            chk("burst_ready", bus.wr_ready, cnt_m < 2);
            chk("burst_rvalid", bus.scan_rvalid, i > 0);
            if (bus.wr_valid && cnt_m < 2) begin
                acc++;
                cnt_m++;
            end
            @(posedge clk);
        end
        chk("burst_accepted", acc, 2);

        got = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            idle_inputs();
            if (acc < 3) begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = wa[acc];
                bus.wr_data  = wd[acc];
            end
            #1;
            if (c == 0) chk("burst_rvalid_tail", bus.scan_rvalid, 1);
            chk("drain_we", bus.ram_we, cnt_m > 0);
            if (cnt_m > 0 && got < 3) begin
                chk("drain_addr", bus.ram_addr, {1'b1, wa[got]});
                chk("drain_wdata", bus.ram_wdata, wd[got]);
                got++;
            end
            push_m = bus.wr_valid && (cnt_m < 2);
            pop_m  = cnt_m > 0;
            cnt_m  = cnt_m + int'(push_m) - int'(pop_m);
            if (push_m) acc++;
            @(posedge clk);
        end
        chk("drain_count", got, 3);

        // Swap to bank 1, fill FIFO, pend another swap, then reset mid-cycle
        @(negedge clk);
        idle_inputs();
        bus.swap_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        bus.frame_sync = 1'b1;
        #1;
        chk("pre_rst_pend", bus.swap_pending, 1);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("pre_rst_bank", bus.display_bank, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_inputs();
            bus.scan_req  = 1'b1;
            bus.scan_addr = 10'h001;
            bus.wr_valid  = 1'b1;
            bus.wr_addr   = 10'h030 + AW'(i);
            bus.wr_data   = 36'h7;
            @(posedge clk);
        end
        @(negedge clk);
        idle_inputs();
        bus.scan_req = 1'b1;
        bus.swap_req = 1'b1;
        #1;
        chk("pre_rst_full", bus.wr_ready, 0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        bus.scan_req = 1'b1;
        #1;
        chk("pre_rst_pend2", bus.swap_pending, 1);
        chk("pre_rst_rvalid", bus.scan_rvalid, 1);
        #1;
        reset = 1'b0;
        bus.scan_req = 1'b0;
        #1;
        chk("mid_rst_bank", bus.display_bank, 0);
        chk("mid_rst_pend", bus.swap_pending, 0);
        chk("mid_rst_rvalid", bus.scan_rvalid, 0);
        chk("mid_rst_we", bus.ram_we, 0);
        chk("mid_rst_ready", bus.wr_ready, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            chk("post_rst_we", bus.ram_we, 0);
            chk("post_rst_addr", bus.ram_addr, 0);
        end
        @(negedge clk);
        idle_inputs();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 10'h031;
        bus.wr_data  = 36'h8;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("post_rst_write_we", bus.ram_we, 1);
        chk("post_rst_write_addr", bus.ram_addr, 11'h431);
        chk("post_rst_write_data", bus.ram_wdata, 36'h8);
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/framebuffer_arbiter.md
Name: framebuffer_arbiter

Overview:
- Shares one single-port, synchronous-read pixel RAM between two requesters: the panel scan read side (driven from the scan's column/row address and pixel load strobe) and a host write side (UART/SPI loader).
- Double-buffers the RAM as two banks. The scan reads the front bank while the host writes the back bank.
- Bank swaps happen only at a frame boundary, so the panel never shows a half-written frame.

Parameters:
- ADDR_WIDTH, 10, pixel-pair address width within one bank: {row[3:0], column[5:0]}.
- DATA_WIDTH, 36, pixel-pair word width: top and bottom pixel, RGB, 6 bits per channel.

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- scan_req  input  1  read strobe from the scan side (the pixel load enable). Level-sensitive: one read per cycle while high.
- scan_addr  input  ADDR_WIDTH  read address, {row_address, column_address}.
- scan_rdata  output  DATA_WIDTH  read data; equals ram_rdata.
- scan_rvalid  output  1  high the cycle after a scan read was issued.
- frame_sync  input  1  one-cycle pulse at a frame boundary (row wraps to 0).
- wr_valid  input  1  host write request.
- wr_ready  output  1  host write accept. A transfer occurs when wr_valid && wr_ready at a clock edge.
- wr_addr  input  ADDR_WIDTH  host write address within the back bank.
- wr_data  input  DATA_WIDTH  host write data.
- swap_req  input  1  one-cycle pulse requesting a front/back swap.
- swap_pending  output  1  a swap has been requested and has not yet executed.
- swap_done  output  1  one-cycle pulse the cycle after a swap executes.
- display_bank  output  1  current front bank.
- ram_addr  output  ADDR_WIDTH+1  RAM address, {bank, addr}.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after the address is presented.

Behaviour:
- Reset values (reset = 0, asynchronous): display_bank=0, FIFO empty, swap_pending=0, swap_done=0, scan_rvalid=0.
  - wr_ready=1 once reset releases.
- RAM port outputs are combinational from the current-cycle selection. With no access selected: ram_we=0 and ram_addr=0.
- Write FIFO: 2 entries, each holding {wr_addr, wr_data}. An accepted transfer enqueues at the edge.
- wr_ready = (count < 2) && !swap_pending. wr_ready is registered-state only, with no combinational path from scan_req or wr_valid.
- Arbitration each cycle:
  - The scan has absolute priority, with no stall.
  - If scan_req=1: ram_addr={display_bank, scan_addr}, ram_we=0, and scan_rvalid=1 in the next cycle.
  - Else if the FIFO is non-empty: drain the head entry. ram_addr={~display_bank, head.addr}, ram_wdata=head.data, ram_we=1; the entry is popped at the edge.
  - Else: idle (ram_we=0).
- Enqueue and drain in the same cycle is allowed; count stays unchanged.
  - A full FIFO whose head drains does not raise wr_ready until the next cycle.
- Writes drain in FIFO order; none are dropped. Write latency from accept to ram_we is at least 1 cycle and unbounded while scan_req stays high.
- Swap:
  - swap_req sets swap_pending. A swap_req while already pending is ignored.
  - The swap executes at the first edge where frame_sync && swap_pending && FIFO empty. At that edge: display_bank toggles, swap_pending clears, and swap_done pulses in the following cycle.
  - If frame_sync arrives with the FIFO non-empty, the swap waits for the next frame_sync.
  - swap_req and frame_sync in the same cycle: pending is set only; the swap executes no earlier than the next frame_sync.
- A scan read in the same cycle the swap executes uses the old display_bank. Reads from the next cycle onward use the new bank.
- Reset mid-operation: FIFO contents are discarded, pending swap cancelled, bank returns to 0, and any in-flight scan_rvalid is cleared.
- Address arithmetic has no wrap logic. Addresses pass through unmodified; the bank bit is the MSB.

Test Plan:
- Reset then idle: wr_ready=1, ram_we=0, display_bank=0. Assert reset=0 mid-write burst → outputs return to reset values immediately; no ram_we after release until a new accept.
- Host writes addr 0x005 then 0x006 (data 0xA5A5A5A5A, 0x123456789) with scan_req=0 → ram_we on consecutive cycles at ram_addr 0x405 and 0x406, in order.
- scan_req high for 64 cycles, addr 0x3C0..0x3FF, with host offering 3 writes → FIFO fills at 2 and wr_ready=0. Every scan read hits bank 0, scan_rvalid follows each read by 1 cycle, and all 3 writes land after scan_req drops, none lost.
- swap_req with the FIFO holding 1 entry and scan_req high through the next frame_sync → no swap at that frame_sync; swap occurs at the following frame_sync (FIFO drained). display_bank=1, swap_done pulses once, wr_ready=0 throughout the pending period.
- After the swap, a host write to 0x010 → ram_addr 0x010 (bank 0). A scan read of 0x010 → ram_addr 0x410 (bank 1).
- swap_req and frame_sync in the same cycle with the FIFO empty → swap_pending=1, no toggle; toggle at the next frame_sync. A second swap_req while pending → exactly one toggle.
